ldst_sequencer: RTL

- Hardwired control sequencer for the bus datapath.
- Steps the datapath's register-transfer enables through instruction fetch, then executes ld, ldi and st.
- Handles a ready handshake with memory and has a bounded-wait fault.
- Replaces hand-timed enable toggling in benches: the datapath is driven one control step per clk cycle.

---
 rtl/ldst_sequencer.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ldst_sequencer.sv
// Hardwired control sequencer: fetch, then ld / ldi / st, with a mem_ready handshake and a bounded-wait fault.
// Optional single-step debug input 'step' is enabled by defining LDST_STEP_EN.
module ldst_sequencer #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter logic [4:0]  OP_LD      = 5'b10100,
    parameter logic [4:0]  OP_LDI     = 5'b10101,
    parameter logic [4:0]  OP_ST      = 5'b10110
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mem_ready,
`ifdef LDST_STEP_EN
    input  logic        step,
`endif
    output logic        PCout,
    output logic        incPC,
    output logic        PCins,
    output logic        MARins,
    output logic        MDRins,
    output logic        MDRout,
    output logic        MDRRead,
    output logic        IRins,
    output logic        Yins,
    output logic        ZLOins,
    output logic        ZLOout,
    output logic        ALUen,
    output logic        Cout,
    output logic        BAOut,
    output logic        Gra,
    output logic        Grb,
    output logic        Rin,
    output logic        Rout,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        done,
    output logic        illegal_op,
    output logic        fault,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        T0    = 4'd1,
        T1    = 4'd2,
        T2    = 4'd3,
        T3    = 4'd4,
        T4    = 4'd5,
        T5    = 4'd6,
        T6    = 4'd7,
        T7    = 4'd8,
        FAULT = 4'd9
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic inc_pc;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic mdr_read;
        logic ir_in;
        logic y_in;
        logic zlo_in;
        logic zlo_out;
        logic alu_en;
        logic c_out;
        logic ba_out;
        logic gra;
        logic grb;
        logic r_in;
        logic r_out;
        logic mem_rd;
        logic mem_wr;
        logic done;
    } ctl_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t     state_reg, state_next;
    logic [4:0] op_reg, op_next;
    logic [7:0] wait_reg, wait_next;
    logic       fault_reg, fault_next;
    logic       illegal_reg, illegal_next;
    ctl_t       ctl_reg, ctl_next;
    logic       step_ok;
    logic       mem_step;
    logic       op_legal;
    logic       st_done;
    logic       unused_ir;

`ifdef LDST_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign unused_ir = ^IR[26:0];
    assign op_legal  = (IR[31:27] == OP_LD) || (IR[31:27] == OP_LDI) || (IR[31:27] == OP_ST);

    // States that hold a memory request and therefore wait on mem_ready
    assign mem_step = (state_reg == T1)
                   || (state_reg == T6 && op_reg == OP_LD)
                   || (state_reg == T7 && op_reg == OP_ST);

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        wait_next    = wait_reg;
        fault_next   = fault_reg;
        illegal_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run) state_next = T0;
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                if (step_ok) begin
                    if (mem_step && !mem_ready) begin
                        if (wait_reg == WAIT_LAST) begin
                            state_next = FAULT;
                            fault_next = 1'b1;
                        end else begin
                            wait_next = wait_reg + 8'd1;
                        end
                    end else begin
                        case (state_reg)
                            T0: state_next = T1;
                            T1: state_next = T2;
                            T2: begin
                                op_next = IR[31:27];
                                if (op_legal) begin
                                    state_next = T3;
                                end else begin
                                    illegal_next = 1'b1;
                                    state_next   = run ? T0 : IDLE;
                                end
                            end
                            T3: state_next = T4;
                            T4: state_next = T5;
                            T5: state_next = (op_reg == OP_LDI) ? (run ? T0 : IDLE) : T6;
                            T6: state_next = T7;
                            T7: state_next = run ? T0 : IDLE;
                            default: state_next = IDLE;
                        endcase
                    end
                end
            end
        endcase
        if (state_next != state_reg) wait_next = 8'd0;
    end

    // Strobes are registered from the upcoming state so they line up with state_reg
    always_comb begin
        ctl_next = '0;
        case (state_next)
            T0: begin
                ctl_next.pc_out = 1'b1;
                ctl_next.mar_in = 1'b1;
                ctl_next.inc_pc = 1'b1;
                ctl_next.zlo_in = 1'b1;
            end
            T1: begin
                ctl_next.zlo_out  = 1'b1;
                ctl_next.pc_in    = 1'b1;
                ctl_next.mdr_read = 1'b1;
                ctl_next.mdr_in   = 1'b1;
                ctl_next.mem_rd   = 1'b1;
            end
            T2: begin
                ctl_next.mdr_out = 1'b1;
                ctl_next.ir_in   = 1'b1;
            end
            T3: begin
                ctl_next.grb    = 1'b1;
                ctl_next.ba_out = 1'b1;
                ctl_next.r_out  = 1'b1;
                ctl_next.y_in   = 1'b1;
            end
            T4: begin
                ctl_next.c_out  = 1'b1;
                ctl_next.alu_en = 1'b1;
                ctl_next.zlo_in = 1'b1;
            end
            T5: begin
                ctl_next.zlo_out = 1'b1;
                if (op_next == OP_LDI) begin
                    ctl_next.gra  = 1'b1;
                    ctl_next.r_in = 1'b1;
                    ctl_next.done = 1'b1;
                end else begin
                    ctl_next.mar_in = 1'b1;
                end
            end
            T6: begin
                if (op_next == OP_LD) begin
                    ctl_next.mdr_read = 1'b1;
                    ctl_next.mdr_in   = 1'b1;
                    ctl_next.mem_rd   = 1'b1;
                end else begin
                    ctl_next.gra    = 1'b1;
                    ctl_next.r_out  = 1'b1;
                    ctl_next.mdr_in = 1'b1;
                end
            end
            T7: begin
                ctl_next.mdr_out = 1'b1;
                if (op_next == OP_LD) begin
                    ctl_next.gra  = 1'b1;
                    ctl_next.r_in = 1'b1;
                    ctl_next.done = 1'b1;
                end else begin
                    ctl_next.mem_wr = 1'b1;
                end
            end
            default: ctl_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= IDLE;
            op_reg      <= 5'd0;
            wait_reg    <= 8'd0;
            fault_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            ctl_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            wait_reg    <= wait_next;
            fault_reg   <= fault_next;
            illegal_reg <= illegal_next;
            ctl_reg     <= ctl_next;
        end
    end

    // A store completes in the very cycle memory acknowledges the write
    assign st_done = (state_reg == T7) && (op_reg == OP_ST) && mem_ready && step_ok;

    assign PCout      = ctl_reg.pc_out;
    assign incPC      = ctl_reg.inc_pc;
    assign PCins      = ctl_reg.pc_in;
    assign MARins     = ctl_reg.mar_in;
    assign MDRins     = ctl_reg.mdr_in;
    assign MDRout     = ctl_reg.mdr_out;
    assign MDRRead    = ctl_reg.mdr_read;
    assign IRins      = ctl_reg.ir_in;
    assign Yins       = ctl_reg.y_in;
    assign ZLOins     = ctl_reg.zlo_in;
    assign ZLOout     = ctl_reg.zlo_out;
    assign ALUen      = ctl_reg.alu_en;
    assign Cout       = ctl_reg.c_out;
    assign BAOut      = ctl_reg.ba_out;
    assign Gra        = ctl_reg.gra;
    assign Grb        = ctl_reg.grb;
    assign Rin        = ctl_reg.r_in;
    assign Rout       = ctl_reg.r_out;
    assign mem_rd     = ctl_reg.mem_rd;
    assign mem_wr     = ctl_reg.mem_wr;
    assign done       = ctl_reg.done | st_done;
    assign illegal_op = illegal_reg;
    assign fault      = fault_reg;
    assign state_dbg  = state_reg;

endmodule
